// File: rtl/sine_table_loader.sv
// Boot-time loader for the quarter-wave sine table RAM: it accepts host words over a
// valid/ready handshake, writes them out in index order, and flags when the table is complete.
module sine_table_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 15
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Start,
  input  logic                  i_WriteValid,
  input  logic [15:0]           i_WriteData,
  output logic                  o_WriteReady,
  output logic                  o_RamWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_RamWriteAddress,
  output logic [DATA_WIDTH-1:0] o_RamWriteData,
  output logic                  o_Busy,
  output logic                  o_TableReady,
  output logic                  o_Error,
  output logic [15:0]           o_Checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [15:0]           SAMPLE_MASK = 16'((32'd1 << DATA_WIDTH) - 32'd1);
  localparam logic [ADDR_WIDTH-1:0] INDEX_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] INDEX_LAST  = '1;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] index, index_next;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_next;
  logic [DATA_WIDTH-1:0] wr_data, wr_data_next;
  logic                  wr_en, wr_en_next;
  logic [15:0]           checksum, checksum_next;
  logic                  accept;
  logic                  word_ok;
  logic [15:0]           sample;

  assign accept  = i_WriteValid && (state == LOAD);
  assign word_ok = (i_WriteData & ~SAMPLE_MASK) == 16'd0;
  assign sample  = i_WriteData & SAMPLE_MASK;

  always_comb begin
    state_next    = state;
    index_next    = index;
    wr_addr_next  = wr_addr;
    wr_data_next  = wr_data;
    wr_en_next    = 1'b0;
    checksum_next = checksum;
    // A start always wins, so a word accepted on the same edge is dropped.
    if (i_Start) begin
      state_next    = LOAD;
      index_next    = '0;
      checksum_next = '0;
    end else if (accept) begin
      if (word_ok) begin
        wr_en_next    = 1'b1;
        wr_addr_next  = index;
        wr_data_next  = sample[DATA_WIDTH-1:0];
        checksum_next = checksum + sample;
        index_next    = index + INDEX_ONE;
        if (index == INDEX_LAST) begin
          state_next = DONE;
        end
      end else begin
        state_next = ERROR;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state    <= IDLE;
      index    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      checksum <= '0;
    end else begin
      state    <= state_next;
      index    <= index_next;
      wr_addr  <= wr_addr_next;
      wr_data  <= wr_data_next;
      wr_en    <= wr_en_next;
      checksum <= checksum_next;
    end
  end

  assign o_WriteReady      = (state == LOAD);
  assign o_Busy            = (state == LOAD);
  assign o_TableReady      = (state == DONE);
  assign o_Error           = (state == ERROR);
  assign o_RamWriteEnable  = wr_en;
  assign o_RamWriteAddress = wr_addr;
  assign o_RamWriteData    = wr_data;
  assign o_Checksum        = checksum;

endmodule

// File: tb/tb_sine_table_loader.sv
// Directed bench for sine_table_loader: a small 16-entry instance for handshake and corner
// cases, plus a default-size instance loaded with a full quarter-wave sine image.
module tb_sine_table_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-entry instance
  logic        start = 1'b0, valid = 1'b0;
  logic [15:0] wdata = 16'd0;
  logic        wready, we, busy, tready, err;
  logic [3:0]  addr;
  logic [14:0] rdata;
  logic [15:0] cksum;

  // full-size instance
  logic        f_start = 1'b0, f_valid = 1'b0;
  logic [15:0] f_wdata = 16'd0;
  logic        f_wready, f_we, f_busy, f_tready, f_err;
  logic [13:0] f_addr;
  logic [14:0] f_rdata;
  logic [15:0] f_cksum;

  sine_table_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(15)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start), .i_WriteValid(valid),
    .i_WriteData(wdata), .o_WriteReady(wready), .o_RamWriteEnable(we),
    .o_RamWriteAddress(addr), .o_RamWriteData(rdata), .o_Busy(busy),
    .o_TableReady(tready), .o_Error(err), .o_Checksum(cksum)
  );

  sine_table_loader dut_full (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(f_start), .i_WriteValid(f_valid),
    .i_WriteData(f_wdata), .o_WriteReady(f_wready), .o_RamWriteEnable(f_we),
    .o_RamWriteAddress(f_addr), .o_RamWriteData(f_rdata), .o_Busy(f_busy),
    .o_TableReady(f_tready), .o_Error(f_err), .o_Checksum(f_cksum)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the small instance, then sample just after the edge.
  task automatic cyc(input logic s, input logic v, input logic [15:0] d);
    @(negedge clk);
    start = s;
    valid = v;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        s;
    logic        v;
    logic [15:0] d;
    logic        we;
    logic [3:0]  a;
    logic [14:0] q;
    logic        busy;
    logic        err;
    logic [15:0] ck;
  } vec_t;

  vec_t        tbl [13];
  logic [15:0] img [16384];

  initial begin
    int          n, strobes, bad;
    logic [15:0] exp_sum;

    // start / data / abort / wrap / start-vs-accept sequence, applied right after reset
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 15'h0000, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 4'd0, 15'h0003, 1'b1, 1'b0, 16'd3};
    tbl[2]  = '{1'b0, 1'b1, 16'h0005, 1'b1, 4'd1, 15'h0005, 1'b1, 1'b0, 16'd8};
    tbl[3]  = '{1'b0, 1'b0, 16'h1234, 1'b0, 4'd1, 15'h0005, 1'b1, 1'b0, 16'd8};
    tbl[4]  = '{1'b0, 1'b1, 16'h0007, 1'b1, 4'd2, 15'h0007, 1'b1, 1'b0, 16'd15};
    tbl[5]  = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 4'd3, 15'h7FFF, 1'b1, 1'b0, 16'd32782};
    tbl[6]  = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 4'd4, 15'h7FFF, 1'b1, 1'b0, 16'd13};
    tbl[7]  = '{1'b0, 1'b1, 16'h8001, 1'b0, 4'd4, 15'h7FFF, 1'b0, 1'b1, 16'd13};
    tbl[8]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 4'd4, 15'h7FFF, 1'b0, 1'b1, 16'd13};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd4, 15'h7FFF, 1'b1, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 1'b1, 16'h0009, 1'b1, 4'd0, 15'h0009, 1'b1, 1'b0, 16'd9};
    tbl[11] = '{1'b1, 1'b1, 16'h0002, 1'b0, 4'd0, 15'h0009, 1'b1, 1'b0, 16'd0};
    tbl[12] = '{1'b0, 1'b1, 16'h0004, 1'b1, 4'd0, 15'h0004, 1'b1, 1'b0, 16'd4};

    exp_sum = 16'd0;
    for (int i = 0; i < 16384; i++) begin
      img[i]  = 16'($rtoi(32767.0 * $sin((real'(i) + 0.5) * 3.14159265358979 / 32768.0)));
      exp_sum = exp_sum + img[i];
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_wready", wready, 0);
    chk("reset_tready", tready, 0);
    chk("reset_err", err, 0);
    chk("reset_we", we, 0);
    chk("reset_cksum", cksum, 0);
    chk("reset_f_tready", f_tready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].s, tbl[i].v, tbl[i].d);
      $display("[TB] vec %0d start=%0b valid=%0b data=%h -> we=%0b addr=%0d q=%h ck=%0d",
               i, tbl[i].s, tbl[i].v, tbl[i].d, we, addr, rdata, cksum);
      chk($sformatf("vec%0d_we", i), we, tbl[i].we);
      chk($sformatf("vec%0d_addr", i), addr, tbl[i].a);
      chk($sformatf("vec%0d_data", i), rdata, tbl[i].q);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_wready", i), wready, tbl[i].busy);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
      chk($sformatf("vec%0d_tready", i), tready, 0);
      chk($sformatf("vec%0d_cksum", i), cksum, tbl[i].ck);
    end

    // back-to-back load of 0..15
    $display("[TB] seq back-to-back load");
    cyc(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 16'(i));
      chk($sformatf("b2b%0d_we", i), we, 1);
      chk($sformatf("b2b%0d_addr", i), addr, 32'(i));
      chk($sformatf("b2b%0d_data", i), rdata, 32'(i));
      chk($sformatf("b2b%0d_tready", i), tready, (i == 15) ? 1 : 0);
    end
    chk("b2b_cksum", cksum, 120);
    chk("b2b_busy", busy, 0);
    cyc(1'b0, 1'b1, 16'd5);
    chk("b2b_after_we", we, 0);
    chk("b2b_after_wready", wready, 0);
    chk("b2b_after_tready", tready, 1);

    // valid toggled every other cycle
    $display("[TB] seq toggled valid load");
    cyc(1'b1, 1'b0, 16'd0);
    n = 0;
    strobes = 0;
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 0) begin
        cyc(1'b0, 1'b1, 16'(100 + n));
        chk($sformatf("tog%0d_we", c), we, 1);
        chk($sformatf("tog%0d_addr", c), addr, 32'(n));
        chk($sformatf("tog%0d_data", c), rdata, 32'(100 + n));
        n++;
      end else begin
        cyc(1'b0, 1'b0, 16'hFFFF);
        chk($sformatf("tog%0d_we", c), we, 0);
      end
      if (we) strobes++;
    end
    chk("tog_strobes", strobes, 16);
    chk("tog_tready", tready, 1);
    chk("tog_cksum", cksum, 1720);

    // restart after 7 accepted words
    $display("[TB] seq restart mid-load");
    cyc(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 16'(i + 1));
    chk("rst7_cksum", cksum, 28);
    chk("rst7_addr", addr, 6);
    cyc(1'b1, 1'b0, 16'd0);
    chk("rst7_start_we", we, 0);
    chk("rst7_start_cksum", cksum, 0);
    chk("rst7_start_busy", busy, 1);
    cyc(1'b0, 1'b1, 16'd11);
    chk("rst7_next_we", we, 1);
    chk("rst7_next_addr", addr, 0);
    chk("rst7_next_data", rdata, 11);
    chk("rst7_next_cksum", cksum, 11);

    // asynchronous reset between edges
    $display("[TB] seq async reset mid-load");
    cyc(1'b0, 1'b1, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wready", wready, 0);
    chk("arst_tready", tready, 0);
    chk("arst_err", err, 0);
    chk("arst_we", we, 0);
    chk("arst_addr", addr, 0);
    chk("arst_data", rdata, 0);
    chk("arst_cksum", cksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'd7);
      chk($sformatf("arst_idle%0d_wready", i), wready, 0);
      chk($sformatf("arst_idle%0d_we", i), we, 0);
    end
    cyc(1'b0, 1'b0, 16'd0);

    // full-size sine image
    $display("[TB] seq full sine image, 16384 words");
    @(negedge clk);
    f_start = 1'b1;
    bad = 0;
    strobes = 0;
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      f_start = 1'b0;
      f_valid = 1'b1;
      f_wdata = img[i];
      @(posedge clk);
      #1;
      if (f_we) strobes++;
      if (f_we !== 1'b1 || f_addr !== 14'(i) || f_rdata !== img[i][14:0]) bad++;
      if (i < 16383 && f_tready !== 1'b0) bad++;
    end
    chk("full_strobes", strobes, 16384);
    chk("full_bad_strobes", bad, 0);
    chk("full_tready", f_tready, 1);
    chk("full_busy", f_busy, 0);
    chk("full_err", f_err, 0);
    chk("full_cksum", f_cksum, exp_sum);
    @(negedge clk);
    f_valid = 1'b0;
    f_start = 1'b1;
    @(posedge clk);
    #1;
    chk("full_restart_tready", f_tready, 0);
    chk("full_restart_busy", f_busy, 1);
    chk("full_restart_cksum", f_cksum, 0);
    @(negedge clk);
    f_start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
